// File: rtl/burst_read_line_buffer.sv
// AXI4 INCR burst read master feeding a circular line buffer and a valid/ready word stream.
// Optional RLAST cross-check against the beat counter: define BRLB_RLAST_CHECK_EN.
module burst_read_line_buffer #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH         = 64
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]                   total_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LEN_W = $clog2(C_M_AXI_BURST_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      next_addr_q, next_addr_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               arvalid_q, arvalid_d;
  logic [AW-1:0]      araddr_q, araddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic               rready_q, rready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic [DW-1:0]      line_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]   fifo_count, free_slots;
  logic               fifo_empty, fifo_full;
  logic [LEN_W-1:0]   burst_len;
  logic               beat_fire, last_beat, push, pop;

  assign fifo_count = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                      (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
  // Only one burst is ever outstanding, so in ISSUE nothing is reserved beyond the occupancy.
  assign free_slots = PTR_W'(FIFO_DEPTH) - fifo_count;
  assign burst_len  = (remaining_q >= 16'(C_M_AXI_BURST_LEN)) ? LEN_W'(C_M_AXI_BURST_LEN)
                                                              : LEN_W'(remaining_q);
  assign beat_fire  = rready_q & M_AXI_RVALID;
  assign last_beat  = (beat_cnt_q == len_q - LEN_W'(1));
  assign push       = beat_fire & ~fifo_full;
  assign pop        = ~fifo_empty & (~out_valid_q | out_ready);

`ifndef BRLB_RLAST_CHECK_EN
  logic rlast_unused;
  assign rlast_unused = M_AXI_RLAST;
`endif

  // Next-state, buffer pointers and output stage.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    rready_d    = rready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    wptr_d      = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = line_mem[rptr_q[PTR_W-2:0]];
      rptr_d      = rptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          next_addr_d = base_addr;
          remaining_d = total_beats;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = (total_beats == 16'd0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!arvalid_q) begin
          if (32'(free_slots) >= 32'(burst_len)) begin
            arvalid_d = 1'b1;
            araddr_d  = next_addr_q;
            arlen_d   = 8'(burst_len - LEN_W'(1));
            len_d     = burst_len;
          end
        end else if (M_AXI_ARREADY) begin
          arvalid_d   = 1'b0;
          next_addr_d = next_addr_q + AW'({len_q, 2'b00});
          remaining_d = remaining_q - 16'(len_q);
          beat_cnt_d  = '0;
          rready_d    = 1'b1;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (M_AXI_RRESP != 2'b00) error_d = 1'b1;
          if (fifo_full) error_d = 1'b1;
`ifdef BRLB_RLAST_CHECK_EN
          if (M_AXI_RLAST != last_beat) error_d = 1'b1;
`endif
          if (last_beat) begin
            rready_d = 1'b0;
            state_d  = (remaining_q != 16'd0) ? S_ISSUE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The output register still holds a word until the consumer takes it.
        if (fifo_empty && !out_valid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      next_addr_q <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) line_mem[wptr_q[PTR_W-2:0]] <= M_AXI_RDATA;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;

endmodule

// File: tb/tb_burst_read_line_buffer.sv
// Bench for burst_read_line_buffer: AXI slave model, transaction-level reference model, directed tests.
// Build with or without BRLB_RLAST_CHECK_EN; the early-RLAST expectation follows the macro.
module tb_burst_read_line_buffer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] total_beats;
  logic        busy, done, error;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] out_data;
  logic        out_valid, out_ready;

  burst_read_line_buffer dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
    .total_beats(total_beats), .busy(busy), .done(done), .error(error),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: word at byte address a is a/4 - 0x400, so base 0x1000 reads 0,1,2,...
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a >> 2) - 32'h400;
  endfunction

  // Reference model state for the transfer in flight.
  logic [31:0] exp_base;
  int          exp_total, issued, words, done_cnt, ar_cnt;
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  logic [31:0] out_log[$];

  // Slave model state.
  logic [31:0] sl_addr_q[$];
  logic [7:0]  sl_len_q[$];
  int          sl_beat, sl_beat_g, sl_err_beat, sl_early, sl_cyc;

  // AXI slave: decides ARREADY/R for the coming edge; handshakes are known from stable values.
  initial begin
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
    M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
    sl_beat = 0; sl_cyc = 0;
    forever begin
      @(posedge ACLK); #2;
      if (ARESET) begin
        sl_addr_q.delete(); sl_len_q.delete(); sl_beat = 0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
      end else begin
        sl_cyc++;
        if (sl_addr_q.size() > 0) begin
          M_AXI_RVALID = (sl_cyc % 5) != 4;
          M_AXI_RDATA  = word_of(sl_addr_q[0] + 32'(sl_beat * 4));
          M_AXI_RRESP  = (sl_beat_g == sl_err_beat) ? 2'b10 : 2'b00;
          M_AXI_RLAST  = (sl_beat == int'(sl_len_q[0])) || (sl_beat_g == sl_early);
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            sl_beat_g++;
            if (sl_beat == int'(sl_len_q[0])) begin
              void'(sl_addr_q.pop_front()); void'(sl_len_q.pop_front()); sl_beat = 0;
            end else sl_beat++;
          end
        end else begin
          M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
        end
        M_AXI_ARREADY = (sl_cyc % 3) == 0;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          sl_addr_q.push_back(M_AXI_ARADDR); sl_len_q.push_back(M_AXI_ARLEN);
        end
      end
    end
  end

  // Compare process: every cycle, check handshake-stability rules and each transaction vs the model.
  logic        prev_arv, prev_ardy, prev_ov, prev_ordy, prev_busy;
  logic [31:0] prev_araddr, prev_od;
  logic [7:0]  prev_arlen;
  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_arv = 0; prev_ardy = 0; prev_ov = 0; prev_ordy = 0; prev_busy = 0;
    end else begin
      if (prev_arv && !prev_ardy) begin
        chk("ar_hold_valid", 32'(M_AXI_ARVALID), 32'd1);
        chk("ar_hold_addr", M_AXI_ARADDR, prev_araddr);
        chk("ar_hold_len", 32'(M_AXI_ARLEN), 32'(prev_arlen));
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        int len;
        chk("ar_within_total", 32'(issued < exp_total), 32'd1);
        len = (exp_total - issued > 16) ? 16 : exp_total - issued;
        chk("ar_addr", M_AXI_ARADDR, exp_base + 32'(issued * 4));
        chk("ar_len", 32'(M_AXI_ARLEN), 32'(len - 1));
        ar_addr_log.push_back(M_AXI_ARADDR); ar_len_log.push_back(M_AXI_ARLEN);
        if (len > 0) issued += len;
        ar_cnt++;
      end
      if (prev_ov && !prev_ordy) begin
        chk("out_hold_valid", 32'(out_valid), 32'd1);
        chk("out_hold_data", out_data, prev_od);
      end
      if (out_valid && out_ready) begin
        chk("out_within_total", 32'(words < exp_total), 32'd1);
        chk("out_data", out_data, word_of(exp_base + 32'(words * 4)));
        out_log.push_back(out_data);
        words++;
      end
      if (done) begin
        chk("done_all_words", 32'(words), 32'(exp_total));
        chk("done_all_ars", 32'(issued), 32'(exp_total));
        chk("busy_low_with_done", 32'(busy), 32'd0);
        chk("busy_high_before_done", 32'(prev_busy), 32'd1);
        done_cnt++;
      end
      prev_arv = M_AXI_ARVALID; prev_ardy = M_AXI_ARREADY; prev_araddr = M_AXI_ARADDR;
      prev_arlen = M_AXI_ARLEN; prev_ov = out_valid; prev_ordy = out_ready;
      prev_od = out_data; prev_busy = busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  task automatic set_model(input logic [31:0] base, input int total);
    exp_base = base; exp_total = total; issued = 0; words = 0;
    ar_addr_log.delete(); ar_len_log.delete(); out_log.delete();
  endtask

  task automatic run_xfer(input logic [31:0] base, input int total, input int errb,
                          input int early, input bit exp_err, input bit restart, input bit bp);
    int d0, a0, t;
    set_model(base, total);
    d0 = done_cnt; a0 = ar_cnt;
    sl_err_beat = errb; sl_early = early; sl_beat_g = 0;
    out_ready = !bp;
    start = 1'b1; base_addr = base; total_beats = 16'(total);
    cyc(1);
    start = 1'b0; base_addr = 32'hDEAD_BEE0; total_beats = 16'hFFFF;
    chk("error_cleared_by_start", 32'(error), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    if (restart) begin
      cyc(3);
      start = 1'b1; base_addr = 32'h8000; total_beats = 16'd5;
      cyc(1);
      start = 1'b0;
    end
    if (bp) begin
      t = 0;
      while (ar_cnt - a0 < 4 && t < 3000) begin cyc(1); t++; end
      cyc(100);
      chk("bp_ar_count", 32'(ar_cnt - a0), 32'd4);
      chk("bp_arvalid_low", 32'(M_AXI_ARVALID), 32'd0);
      chk("bp_no_words", 32'(words), 32'd0);
      out_ready = 1'b1;
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin cyc(1); t++; end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    cyc(8);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("error_final", 32'(error), 32'(exp_err));
    chk("ar_total", 32'(ar_cnt - a0), 32'((total + 15) / 16));
    chk("word_total", 32'(words), 32'(total));
  endtask

  initial begin
    int t;
    ARESET = 1'b1; start = 1'b0; base_addr = '0; total_beats = '0; out_ready = 1'b1;
    exp_base = '0; exp_total = 0; issued = 0; words = 0; done_cnt = 0; ar_cnt = 0;
    sl_beat_g = 0; sl_err_beat = -1; sl_early = -1;
    @(negedge ACLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("rst_araddr", M_AXI_ARADDR, 32'd0);
    chk("rst_arlen", 32'(M_AXI_ARLEN), 32'd0);
    chk("rst_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("arsize", 32'(M_AXI_ARSIZE), 32'd2);
    chk("arburst", 32'(M_AXI_ARBURST), 32'd1);
    cyc(3);
    ARESET = 1'b0;
    cyc(2);

    // Basic fetch, with a second start while busy that must be ignored.
    run_xfer(32'h1000, 32, -1, -1, 1'b0, 1'b1, 1'b0);
    if (ar_addr_log.size() == 2 && out_log.size() == 32) begin
      chk("basic_ar0_addr", ar_addr_log[0], 32'h1000);
      chk("basic_ar0_len", 32'(ar_len_log[0]), 32'd15);
      chk("basic_ar1_addr", ar_addr_log[1], 32'h1040);
      chk("basic_ar1_len", 32'(ar_len_log[1]), 32'd15);
      chk("basic_first_word", out_log[0], 32'd0);
      chk("basic_last_word", out_log[31], 32'd31);
    end else chk("basic_log_sizes", 32'(ar_addr_log.size() * 100 + out_log.size()), 32'd232);

    // Partial last burst.
    run_xfer(32'h1000, 20, -1, -1, 1'b0, 1'b0, 1'b0);
    if (ar_addr_log.size() == 2) begin
      chk("partial_ar1_addr", ar_addr_log[1], 32'h1040);
      chk("partial_ar1_len", 32'(ar_len_log[1]), 32'd3);
    end else chk("partial_ar_count", 32'(ar_addr_log.size()), 32'd2);

    // Backpressure: buffer fills after four bursts.
    run_xfer(32'h4000, 96, -1, -1, 1'b0, 1'b0, 1'b1);

    // Slave error on one beat: sticky through done, cleared by the next start.
    run_xfer(32'h1000, 32, 5, -1, 1'b1, 1'b0, 1'b0);
    cyc(5);
    chk("error_still_sticky", 32'(error), 32'd1);

    // Zero length.
    run_xfer(32'h1000, 0, -1, -1, 1'b0, 1'b0, 1'b0);

    // Address wrap at the top of the address space.
    run_xfer(32'hFFFF_FFC0, 32, -1, -1, 1'b0, 1'b0, 1'b0);
    if (ar_addr_log.size() == 2) chk("wrap_ar1_addr", ar_addr_log[1], 32'h0000_0000);
    else chk("wrap_ar_count", 32'(ar_addr_log.size()), 32'd2);

    // Reset in the middle of a burst.
    set_model(32'h2000, 48);
    sl_err_beat = -1; sl_early = -1; sl_beat_g = 0; out_ready = 1'b1;
    start = 1'b1; base_addr = 32'h2000; total_beats = 16'd48;
    cyc(1);
    start = 1'b0;
    t = 0;
    while (words < 3 && t < 2000) begin cyc(1); t++; end
    chk("midrst_progress", 32'(words >= 3), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    chk("midrst_araddr", M_AXI_ARADDR, 32'd0);
    chk("midrst_arlen", 32'(M_AXI_ARLEN), 32'd0);
    chk("midrst_rready", 32'(M_AXI_RREADY), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    cyc(3);
    set_model(32'h0, 0);
    ARESET = 1'b0;
    cyc(10);
    chk("postrst_empty", 32'(out_valid), 32'd0);
    chk("postrst_idle", 32'(busy), 32'd0);
    run_xfer(32'h3000, 20, -1, -1, 1'b0, 1'b0, 1'b0);

    // Early RLAST on the third beat of the first burst.
`ifdef BRLB_RLAST_CHECK_EN
    run_xfer(32'h1000, 16, -1, 2, 1'b1, 1'b0, 1'b0);
`else
    run_xfer(32'h1000, 16, -1, 2, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/burst_read_line_buffer.md
# burst_read_line_buffer

AXI4 burst read master with an integrated circular line buffer. It fetches a run of 32-bit words from memory in fixed-length INCR bursts and presents them as a valid/ready word stream to the video/pixel consumer. It sits directly downstream of the slave memory and replaces the one-shot burst-read test master as the fetch stage feeding the display path.

## Interface

**Parameters**
- `C_M_AXI_ADDR_WIDTH`, default 32: AXI address width.
- `C_M_AXI_DATA_WIDTH`, default 32: AXI data width. Only 32 is supported.
- `C_M_AXI_BURST_LEN`, default 16: maximum beats per burst. Power of two, 1..256.
- `FIFO_DEPTH`, default 64: line buffer depth in words. Power of two, at least 2×`C_M_AXI_BURST_LEN`.

**Ports**
- `ACLK` in 1: the single clock.
- `ARESET` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request. Sampled only in IDLE.
- `base_addr` in `C_M_AXI_ADDR_WIDTH`: first byte address. Must be aligned to `C_M_AXI_BURST_LEN`×4.
- `total_beats` in 16: number of words to fetch.
- `busy` out 1: high while not in IDLE.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `error` out 1: sticky. Cleared on `start` or reset.
- `M_AXI_ARADDR` out `C_M_AXI_ADDR_WIDTH`, `M_AXI_ARLEN` out 8, `M_AXI_ARSIZE` out 3 (constant 3'b010), `M_AXI_ARBURST` out 2 (constant INCR 2'b01), `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 32, `M_AXI_RRESP` in 2, `M_AXI_RLAST` in 1, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1.
- `out_data` out 32, `out_valid` out 1, `out_ready` in 1: output word stream.

## Operation

**State machine: IDLE → ISSUE → DATA → (ISSUE | DRAIN) → IDLE.**
- **IDLE**
  - On `start`: latch `base_addr` into `next_addr` and `total_beats` into `remaining`, clear `error`.
  - If `total_beats` is 0: go straight to DRAIN, which completes at once. No AR is issued.
- **ISSUE**
  - Compute `len = min(remaining, C_M_AXI_BURST_LEN)`.
  - Hold `M_AXI_ARVALID` low until FIFO free space ≥ `len`. Free space counts reserved, not-yet-received beats as used.
  - Then assert `ARVALID` with `ARADDR = next_addr` and `ARLEN = len-1`.
  - On the `ARVALID`·`ARREADY` cycle:
    - `next_addr += len*4`
    - `remaining -= len`
    - reserve `len` slots
    - go to DATA.
- **DATA**
  - `M_AXI_RREADY` = 1. Each `RVALID`·`RREADY` beat pushes `RDATA` into the FIFO.
  - Any `RRESP` ≠ 2'b00 sets `error`. The data is still pushed.
  - The burst ends after `len` beats. Then go to ISSUE if `remaining` > 0, otherwise go to DRAIN.
  - Only one burst is outstanding at a time.
- **DRAIN**
  - Wait until the FIFO is empty, then pulse `done` for one cycle and go to IDLE.
- **Other rules**
  - `start` outside IDLE is ignored.
  - Address arithmetic wraps modulo 2^`C_M_AXI_ADDR_WIDTH`.
  - Because `base_addr` is aligned, no burst crosses a 4 KB boundary.
- **FIFO**
  - Circular buffer with log2(`FIFO_DEPTH`)+1-bit read/write pointers. Full is signalled by the MSB differing and the low bits being equal.
  - Push and pop in the same cycle are legal and leave the occupancy unchanged.
  - The reservation makes overflow impossible. A push while full is dropped and sets `error`.

## Timing

- **Reset values:**
  - All outputs are 0: `busy`, `done`, `error`, `ARVALID`, `ARADDR`, `ARLEN`, `RREADY`, `out_valid`, `out_data`.
  - `ARSIZE` and `ARBURST` are constants.
  - The FIFO is empty and the state is IDLE.
- **Reset mid-operation:** the state machine returns to IDLE and the FIFO is flushed. `ARVALID` drops immediately, which is permitted under reset. The bench must also reset the slave.
- **`start` to `ARVALID`:** 2 cycles (IDLE→ISSUE, then the space check registered).
- **AR handshake:** once asserted, `ARVALID`, `ARADDR` and `ARLEN` stay stable until `ARREADY`.
- **Write to output:** 1 cycle. A beat accepted at edge N gives `out_valid` high after edge N+1.
- **Output handshake:** `out_data` and `out_valid` stay stable while `out_valid`·!`out_ready`. Sustained throughput is 1 word per cycle.
- **`done`:** asserted in the cycle after the FIFO becomes empty in DRAIN. `busy` falls together with `done`.

## Configuration

- **`BRLB_RLAST_CHECK_EN` defined:**
  - `RLAST` is compared with the internal beat counter.
  - `RLAST` on a beat other than the `len`th, or missing on the `len`th beat, sets `error`.
  - The burst still ends on the counter.
- **Not defined:** `M_AXI_RLAST` is ignored and the burst end is governed only by the beat counter.

## Test plan

- **Basic fetch:** `base_addr` = 0x1000, `total_beats` = 32, slave memory word i = i, `out_ready` = 1.
  - Two ARs: 0x1000/ARLEN 15 and 0x1040/ARLEN 15.
  - Output is 0..31 in order, `done` pulses once, `error` = 0.
- **Partial last burst:** `total_beats` = 20.
  - ARs at 0x1000/ARLEN 15 and 0x1040/ARLEN 3.
  - Exactly 20 words out.
- **Backpressure:** `out_ready` = 0 while 64 beats are fetched.
  - Exactly 4 ARs issue, then `ARVALID` stays low.
  - After releasing `out_ready`, the remaining bursts complete and all words arrive intact.
- **Slave error:** `RRESP` = SLVERR on beat 5.
  - `error` goes high and stays high after `done`.
  - The next `start` clears it.
- **Zero length and ignored start:**
  - `total_beats` = 0 gives a `done` pulse with no AR.
  - A second `start` while `busy` is ignored.
- **Reset and RLAST check:**
  - `ARESET` asserted mid-burst: all outputs go to 0 and the FIFO is empty.
  - With `BRLB_RLAST_CHECK_EN` defined, an early `RLAST` on beat 3 sets `error`.
